stream_mux_onehot: RTL and testbench

//  Parametrised N-channel valid/ready stream multiplexer. Channel select is a one-hot, registered

---
 rtl/stream_mux_pkg.sv | 25 ++
 rtl/stream_mux_onehot_check.sv | 18 +
 rtl/stream_mux_onehot.sv | 164 ++++++++++++++++
 tb/tb_stream_mux_onehot.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the one-hot stream multiplexer.
// FSM state encoding and guard counter sizing live here so the top and the bench agree.
package stream_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam int GUARD_CNT_W = 4;

    // Terminal count of the guard counter; a zero guard never enters GUARD, so 0 is harmless there.
    function automatic logic [GUARD_CNT_W-1:0] guard_last(input int guard);
        logic [GUARD_CNT_W-1:0] last;
        if (guard <= 0) begin
            last = '0;
        end else begin
            last = GUARD_CNT_W'(guard - 1);
        end
        return last;
    endfunction

endpackage

// File: rtl/stream_mux_onehot_check.sv
// Combinational classifier for a select code: all-zero, or exactly one bit set.
// Anything else (two or more bits) is an invalid code for the multiplexer.
module onehot_check #(
    parameter int W = 4
) (
    input  logic [W-1:0] code,
    output logic         is_zero,
    output logic         is_onehot
);

    logic [W-1:0] code_minus_one;

    assign code_minus_one = code - W'(1);
    assign is_zero        = (code == '0);
    // Clearing the lowest set bit leaves nothing only when a single bit was set.
    assign is_onehot      = !is_zero && ((code & code_minus_one) == '0);

endmodule

// File: rtl/stream_mux_onehot.sv
// N-channel valid/ready stream mux with a registered one-hot select that switches only
// after the output register drains and a guard gap elapses. Optional build macro: STREAM_MUX_FLUSH_EN.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are both high;
// valid must not depend on ready, and data is held stable while valid & ~ready.
module stream_mux_onehot
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 4,
    parameter int SWITCH_GUARD = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            sel_in,
    input  logic                         sel_load,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH-1:0]            sel_active,
    output logic                         sel_err,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    localparam logic [GUARD_CNT_W-1:0] GUARD_LAST = guard_last(SWITCH_GUARD);
    localparam bit                     NO_GUARD   = (SWITCH_GUARD == 0);

    state_t                   state, state_nxt;
    logic [NUM_CH-1:0]        pending, pending_nxt;
    logic [NUM_CH-1:0]        active_nxt;
    logic [GUARD_CNT_W-1:0]   guard_cnt, guard_cnt_nxt;

    logic                     sel_is_zero, sel_is_onehot;
    logic                     load_ok, load_bad;
    logic                     out_free;
    logic [NUM_CH-1:0]        run_ready;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    mux_data;

    onehot_check #(.W(NUM_CH)) u_sel_check (
        .code      (sel_in),
        .is_zero   (sel_is_zero),
        .is_onehot (sel_is_onehot)
    );

    assign load_ok  = sel_load && (sel_is_zero || sel_is_onehot);
    assign load_bad = sel_load && !sel_is_zero && !sel_is_onehot;
    // The output register can take a new sample, or (in DRAIN) has emptied this cycle.
    assign out_free = !out_valid || out_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= '0;
            sel_active <= '0;
            guard_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            sel_active <= active_nxt;
            guard_cnt  <= guard_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        active_nxt    = sel_active;
        guard_cnt_nxt = guard_cnt;
        case (state)
            ST_IDLE: begin
                if (load_ok && !sel_is_zero) begin
                    pending_nxt = sel_in;
                    if (NO_GUARD) begin
                        active_nxt = sel_in;
                        state_nxt  = ST_RUN;
                    end else begin
                        guard_cnt_nxt = '0;
                        state_nxt     = ST_GUARD;
                    end
                end
            end
            ST_RUN: begin
                if (load_ok && (sel_in != sel_active)) begin
                    pending_nxt = sel_in;
                    state_nxt   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (load_ok) begin
                    pending_nxt = sel_in;
                end
                if (out_free) begin
                    if (NO_GUARD) begin
                        active_nxt = pending_nxt;
                        state_nxt  = (pending_nxt != '0) ? ST_RUN : ST_IDLE;
                    end else begin
                        guard_cnt_nxt = '0;
                        state_nxt     = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (load_ok) begin
                    pending_nxt   = sel_in;
                    guard_cnt_nxt = '0;
                end else if (guard_cnt == GUARD_LAST) begin
                    active_nxt = pending;
                    state_nxt  = (pending != '0) ? ST_RUN : ST_IDLE;
                end else begin
                    guard_cnt_nxt = guard_cnt + GUARD_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    assign run_ready = (state == ST_RUN) ? (sel_active & {NUM_CH{out_free}}) : '0;
    assign accept    = |(in_valid & run_ready);

`ifdef STREAM_MUX_FLUSH_EN
    // Everything except the live channel is swallowed so upstream never stalls.
    assign in_ready = (state == ST_RUN) ? (run_ready | ~sel_active) : '1;
`else
    assign in_ready = run_ready;
`endif

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_active[k]) begin
                mux_data = mux_data | in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            if (accept) begin
                out_data  <= mux_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            sel_err <= load_bad;
        end
    end

    assign busy      = (state == ST_DRAIN) || (state == ST_GUARD);
    assign dbg_state = state;

endmodule

// File: tb/tb_stream_mux_onehot.sv
// Directed bench for stream_mux_onehot (4 channels, 16-bit samples, guard of 2 cycles).
// Expected in_ready in idle/guard follows STREAM_MUX_FLUSH_EN when that macro is defined.
module tb_stream_mux_onehot;
    import stream_mux_pkg::*;

    localparam int DW = 16;
    localparam int NC = 4;

`ifdef STREAM_MUX_FLUSH_EN
    localparam logic [NC-1:0] IDLE_READY = 4'hF;
`else
    localparam logic [NC-1:0] IDLE_READY = 4'h0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NC-1:0]     sel_in;
    logic              sel_load;
    logic [NC*DW-1:0]  in_data;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [NC-1:0]     sel_active;
    logic              sel_err;
    logic              busy;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    stream_mux_onehot #(.DATA_WIDTH(DW), .NUM_CH(NC), .SWITCH_GUARD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_in     (sel_in),
        .sel_load   (sel_load),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel_active (sel_active),
        .sel_err    (sel_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Distractor samples on every channel so a wrong mux leg shows up.
    task automatic set_data(input logic [DW-1:0] ch1, input logic [DW-1:0] ch3);
        in_data = {ch3, 16'hDEAD, ch1, 16'hBEEF};
    endtask

    initial begin
        rst_n = 1'b0; sel_in = '0; sel_load = 1'b0; in_valid = '0; out_ready = 1'b1;
        set_data(16'h0, 16'h0);
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sel_active", 32'(sel_active), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // 1: load ch1, two guard cycles, first sample
        sel_in = 4'b0010; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        check("t1_guard_state", 32'(dbg_state), 32'(ST_GUARD));
        check("t1_guard_busy", 32'(busy), 32'd1);
        check("t1_guard_ready", 32'(in_ready), 32'(IDLE_READY));
        tick();
        check("t1_guard2_active", 32'(sel_active), 32'd0);
        tick();
        check("t1_active", 32'(sel_active), 32'b0010);
        check("t1_run_state", 32'(dbg_state), 32'(ST_RUN));
        check("t1_busy_low", 32'(busy), 32'd0);
        set_data(16'h1234, 16'hC0DE); in_valid = 4'b1111;
        check("t1_in_ready", 32'(in_ready & 4'b0010), 32'b0010);
        tick();
        in_valid = '0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h1234);
        tick();
        check("t1_out_clear", 32'(out_valid), 32'd0);

        // 2: back-to-back stream 1..8
        for (int i = 1; i <= 8; i++) begin
            set_data(DW'(i), 16'hC0DE); in_valid = 4'b1111;
            tick();
            check($sformatf("t2_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("t2_data_%0d", i), 32'(out_data), 32'(i));
        end
        in_valid = '0;
        tick();
        check("t2_tail_clear", 32'(out_valid), 32'd0);

        // 3: switch to ch3 while the output is stalled
        out_ready = 1'b0;
        set_data(16'h00AA, 16'hC0DE); in_valid = 4'b0010;
        tick();
        check("t3_hold_data", 32'(out_data), 32'h00AA);
        check("t3_stall_ready", 32'(in_ready & 4'b0010), 32'd0);
        set_data(16'h5555, 16'hC0DE);
        sel_in = 4'b1000; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        check("t3_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        check("t3_drain_busy", 32'(busy), 32'd1);
        check("t3_drain_data", 32'(out_data), 32'h00AA);
        tick();
        check("t3_drain_hold", 32'(out_data), 32'h00AA);
        check("t3_drain_valid", 32'(out_valid), 32'd1);
        check("t3_drain_active", 32'(sel_active), 32'b0010);
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        check("t3_guard_state", 32'(dbg_state), 32'(ST_GUARD));
        check("t3_guard_empty", 32'(out_valid), 32'd0);
        check("t3_no_5555", 32'(out_data), 32'h00AA);
        tick();
        check("t3_guard2_active", 32'(sel_active), 32'b0010);
        tick();
        check("t3_active", 32'(sel_active), 32'b1000);
        set_data(16'h7E7E, 16'hC3C3); in_valid = 4'b1010;
        check("t3_in_ready_ch3", 32'(in_ready & 4'b1000), 32'b1000);
        tick();
        in_valid = '0;
        check("t3_ch3_data", 32'(out_data), 32'hC3C3);
        check("t3_ch3_valid", 32'(out_valid), 32'd1);
        tick();

        // 4: invalid code, then a reload of the current code
        sel_in = 4'b0110; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        check("t4_err_pulse", 32'(sel_err), 32'd1);
        check("t4_err_active", 32'(sel_active), 32'b1000);
        check("t4_err_state", 32'(dbg_state), 32'(ST_RUN));
        tick();
        check("t4_err_clear", 32'(sel_err), 32'd0);
        sel_in = 4'b1000; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        check("t4_same_state", 32'(dbg_state), 32'(ST_RUN));
        check("t4_same_busy", 32'(busy), 32'd0);

        // 5: disable, with a restart of the guard
        sel_in = 4'b0000; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        check("t5_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        tick();
        check("t5_guard_state", 32'(dbg_state), 32'(ST_GUARD));
        tick();
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        check("t5_restart_state", 32'(dbg_state), 32'(ST_GUARD));
        tick();
        check("t5_restart_hold", 32'(dbg_state), 32'(ST_GUARD));
        tick();
        check("t5_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t5_idle_active", 32'(sel_active), 32'd0);
        in_valid = 4'b1111;
        check("t5_idle_ready", 32'(in_ready), 32'(IDLE_READY));
        tick();
        check("t5_idle_no_out", 32'(out_valid), 32'd0);
        in_valid = '0;

        // 6: reset in the middle of a stalled sample
        sel_in = 4'b0010; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        tick(); tick();
        check("t6_active", 32'(sel_active), 32'b0010);
        out_ready = 1'b0;
        set_data(16'h7777, 16'hC0DE); in_valid = 4'b0010;
        tick();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_active", 32'(sel_active), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick(); tick(); tick();
        check("t6_no_out", 32'(out_valid), 32'd0);
        check("t6_no_ready", 32'(in_ready), 32'(IDLE_READY));
        check("t6_still_idle", 32'(sel_active), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
